// File: rtl/shuffle_index_gen_if.sv
// rtl/shuffle_index_gen_if.sv - shuffled index stream between the shuffler and the sample fetcher
interface shuffle_index_gen_if #(
    parameter int IDX_W = 4
);
    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx_data;
    logic             idx_last;

    modport master (output idx_valid, output idx_data, output idx_last, input idx_ready);
    modport slave  (input idx_valid, input idx_data, input idx_last, output idx_ready);
endinterface

// File: rtl/shuffle_index_gen.sv
// rtl/shuffle_index_gen.sv - LFSR-driven Fisher-Yates permutation generator for epoch sample order
module shuffle_index_gen #(
    parameter int          N_MAX = 16,
    parameter int          IDX_W = $clog2(N_MAX),
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IDX_W:0]     n_samples,
    input  logic               seed_load,
    input  logic [15:0]        seed,
    output logic               busy,
    output logic               done,
    shuffle_index_gen_if.master idx
);
    typedef enum logic [2:0] {IDLE, INIT, PICK, OUT, DONE} state_t;

    localparam int             PW      = 17 + IDX_W;
    localparam logic [IDX_W:0] N_MAX_V = (IDX_W+1)'(N_MAX);
    localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

    state_t           state, state_nx;
    logic [15:0]      lfsr, lfsr_next;
    logic [IDX_W:0]   n, rem, n_clamp;
    logic [IDX_W-1:0] i, j, pick_j, last_i, tail_i;
    logic [IDX_W-1:0] data_r;
    logic             last_r;
    logic [IDX_W-1:0] tbl [N_MAX];

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    // Scaling by rem keeps j strictly below rem without a modulo.
    assign pick_j    = IDX_W'((PW'(lfsr_next) * PW'(rem)) >> 16);
    assign n_clamp   = (n_samples > N_MAX_V) ? N_MAX_V : n_samples;
    assign last_i    = IDX_W'(n - ONE);
    assign tail_i    = IDX_W'(rem - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (n_samples == '0) ? DONE : INIT;
            INIT: if (i == last_i) state_nx = PICK;
            PICK: state_nx = OUT;
            OUT:  if (idx.idx_ready) state_nx = (rem == ONE) ? DONE : PICK;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        done          = (state == DONE);
        idx.idx_valid = (state == OUT);
        idx.idx_data  = data_r;
        idx.idx_last  = last_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr   <= SEED;
            n      <= '0;
            rem    <= '0;
            i      <= '0;
            j      <= '0;
            data_r <= '0;
            last_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Seed loads in the same cycle as start; the LFSR only steps in PICK.
                    if (seed_load) lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
                    if (start) begin
                        n   <= n_clamp;
                        rem <= n_clamp;
                        i   <= '0;
                    end
                end
                INIT: i <= i + 1'b1;
                PICK: begin
                    lfsr   <= lfsr_next;
                    j      <= pick_j;
                    data_r <= tbl[pick_j];
                    last_r <= (rem == ONE);
                end
                OUT:  if (idx.idx_ready) rem <= rem - ONE;
                DONE: last_r <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) tbl[i] <= i;
        else if (state == OUT && idx.idx_ready) tbl[j] <= tbl[tail_i];
    end
endmodule
